// File: rtl/mem_stage_lsu.sv
// MEM stage of the in-order core: EX->MEM register, variable-latency load wait,
// sub-word load alignment with sign/zero extension, WB drive and ID forwarding.
module mem_stage_lsu #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 32,
  parameter int RF_AW   = 5,
  parameter int STALL_W = 6,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall,
  input  logic [PC_W-1:0]    ex_pc,
  input  logic               ex_rf_we,
  input  logic [RF_AW-1:0]   ex_rf_waddr,
  input  logic [XLEN-1:0]    ex_result,
  input  logic               ex_is_load,
  input  logic [1:0]         ex_ld_size,
  input  logic               ex_ld_unsigned,
  input  logic               ex_hi_we,
  input  logic               ex_lo_we,
  input  logic [XLEN-1:0]    ex_hi,
  input  logic [XLEN-1:0]    ex_lo,
  input  logic               data_rvalid,
  input  logic [XLEN-1:0]    data_rdata,
  output logic [PC_W-1:0]    wb_pc,
  output logic               wb_rf_we,
  output logic [RF_AW-1:0]   wb_rf_waddr,
  output logic [XLEN-1:0]    wb_rf_wdata,
  output logic               wb_hi_we,
  output logic               wb_lo_we,
  output logic [XLEN-1:0]    wb_hi,
  output logic [XLEN-1:0]    wb_lo,
  output logic               fwd_we,
  output logic [RF_AW-1:0]   fwd_waddr,
  output logic [XLEN-1:0]    fwd_wdata,
  output logic               fwd_pending,
  output logic               stallreq_mem,
  output logic               mem_misalign,
  output logic               mem_timeout
);
  localparam int OFS_W = $clog2(XLEN / 8);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic             rf_we;
    logic [RF_AW-1:0] waddr;
    logic [XLEN-1:0]  result;
    logic             is_load;
    logic [1:0]       size;
    logic             uns;
    logic             mis;
    logic             hi_we;
    logic             lo_we;
    logic [XLEN-1:0]  hi;
    logic [XLEN-1:0]  lo;
  } mem_reg_t;

  // Size 3 on a 32-bit core is never legal, whatever the offset.
  function automatic logic misaligned(input logic [OFS_W-1:0] ofs, input logic [1:0] size);
    logic [OFS_W-1:0] mask;
    mask = OFS_W'((32'd1 << size) - 32'd1);
    return ((ofs & mask) != '0) || ((size == 2'd3) && (XLEN == 32));
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [OFS_W-1:0] ofs,
                                                  input logic [1:0] size,
                                                  input logic uns);
    logic [XLEN-1:0]        lane;
    logic [XLEN-1:0]        up;
    logic signed [XLEN-1:0] sext;
    int                     sh;
    lane = word >> {ofs, 3'b000};
    sh   = XLEN - (8 << size);
    if (sh <= 0) return lane;
    up   = lane << sh;
    sext = $signed(up) >>> sh;
    return uns ? (up >> sh) : $unsigned(sext);
  endfunction

  mem_reg_t         reg_q, reg_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  buf_q, buf_d;
  logic             mis_pulse_q, mis_pulse_d;

  logic ex_mis, reg_load, reg_clear, timeout_hit;
  logic unused_stall;

  assign unused_stall = ^{stall[STALL_W-1:5], stall[2:0]};
  assign ex_mis       = ex_is_load && misaligned(ex_result[OFS_W-1:0], ex_ld_size);
  assign reg_clear    = flush || (stall[3] && !stall[4]);
  assign reg_load     = !flush && !stall[3];
  assign timeout_hit  = (state_q == S_WAIT) && !data_rvalid && (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    reg_d       = reg_q;
    mis_pulse_d = 1'b0;
    if (reg_clear) begin
      reg_d = '0;
    end else if (reg_load) begin
      reg_d.pc      = ex_pc;
      reg_d.rf_we   = ex_rf_we;
      reg_d.waddr   = ex_rf_waddr;
      reg_d.result  = ex_result;
      reg_d.is_load = ex_is_load;
      reg_d.size    = ex_ld_size;
      reg_d.uns     = ex_ld_unsigned;
      reg_d.mis     = ex_mis;
      reg_d.hi_we   = ex_hi_we;
      reg_d.lo_we   = ex_lo_we;
      reg_d.hi      = ex_hi;
      reg_d.lo      = ex_lo;
      mis_pulse_d   = ex_mis;
    end
  end

  // WAIT leaves only on data, timeout or flush; the controller holds MEM meanwhile.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else if (state_q == S_WAIT) begin
      if (data_rvalid || timeout_hit) state_d = S_DONE;
    end else if (reg_load) begin
      state_d = (ex_is_load && !ex_mis) ? S_WAIT : S_IDLE;
    end else if (reg_clear) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    cnt_d = '0;
    if (state_d == S_WAIT) cnt_d = (state_q == S_WAIT) ? cnt_q + CNT_W'(1) : CNT_W'(1);
    buf_d = buf_q;
    if (!flush && (state_q == S_WAIT)) begin
      if (data_rvalid)      buf_d = data_rdata;
      else if (timeout_hit) buf_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q       <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      buf_q       <= '0;
      mis_pulse_q <= 1'b0;
    end else begin
      reg_q       <= reg_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      mis_pulse_q <= mis_pulse_d;
    end
  end

  assign wb_pc        = reg_q.pc;
  assign wb_rf_we     = reg_q.rf_we && !reg_q.mis && (state_q != S_WAIT);
  assign wb_rf_waddr  = reg_q.waddr;
  assign wb_rf_wdata  = reg_q.is_load
                        ? load_extend(buf_q, reg_q.result[OFS_W-1:0], reg_q.size, reg_q.uns)
                        : reg_q.result;
  assign wb_hi_we     = reg_q.hi_we;
  assign wb_lo_we     = reg_q.lo_we;
  assign wb_hi        = reg_q.hi;
  assign wb_lo        = reg_q.lo;
  assign fwd_we       = wb_rf_we;
  assign fwd_waddr    = wb_rf_waddr;
  assign fwd_wdata    = wb_rf_wdata;
  assign fwd_pending  = reg_q.is_load && (state_q != S_DONE);
  assign stallreq_mem = (state_q == S_WAIT) && !data_rvalid;
  assign mem_misalign = mis_pulse_q;
  assign mem_timeout  = timeout_hit;

  // The outstanding load must stay parked in MEM until its data is captured.
  a_hold_in_wait: assert property (@(posedge clk) disable iff (rst)
                                   (state_q == S_WAIT) |-> stall[4]);
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu (XLEN=32, TIMEOUT=15).
module tb_mem_stage_lsu;
  localparam int XLEN = 32, PC_W = 32, RF_AW = 5, STALL_W = 6, TIMEOUT = 15;
  localparam logic [5:0] ST_RUN = 6'b000000, ST_HOLD = 6'b011000, ST_BUBBLE = 6'b001000;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [STALL_W-1:0] stall = '0;
  logic [PC_W-1:0] ex_pc = '0;
  logic ex_rf_we = 1'b0, ex_is_load = 1'b0, ex_ld_unsigned = 1'b0;
  logic ex_hi_we = 1'b0, ex_lo_we = 1'b0, data_rvalid = 1'b0;
  logic [RF_AW-1:0] ex_rf_waddr = '0;
  logic [XLEN-1:0] ex_result = '0, ex_hi = '0, ex_lo = '0, data_rdata = '0;
  logic [1:0] ex_ld_size = '0;
  logic [PC_W-1:0] wb_pc;
  logic wb_rf_we, wb_hi_we, wb_lo_we, fwd_we, fwd_pending, stallreq_mem, mem_misalign, mem_timeout;
  logic [RF_AW-1:0] wb_rf_waddr, fwd_waddr;
  logic [XLEN-1:0] wb_rf_wdata, wb_hi, wb_lo, fwd_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage_lsu #(.XLEN(XLEN), .PC_W(PC_W), .RF_AW(RF_AW), .STALL_W(STALL_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .ex_pc(ex_pc), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result),
    .ex_is_load(ex_is_load), .ex_ld_size(ex_ld_size), .ex_ld_unsigned(ex_ld_unsigned),
    .ex_hi_we(ex_hi_we), .ex_lo_we(ex_lo_we), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .wb_pc(wb_pc), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
    .wb_hi_we(wb_hi_we), .wb_lo_we(wb_lo_we), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending),
    .stallreq_mem(stallreq_mem), .mem_misalign(mem_misalign), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    ex_pc = '0; ex_rf_we = 1'b0; ex_rf_waddr = '0; ex_result = '0; ex_is_load = 1'b0;
    ex_ld_size = '0; ex_ld_unsigned = 1'b0; ex_hi_we = 1'b0; ex_lo_we = 1'b0; ex_hi = '0; ex_lo = '0;
  endtask

  task automatic drive_alu(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] res);
    drive_idle();
    ex_pc = pc; ex_rf_we = 1'b1; ex_rf_waddr = wa; ex_result = res;
  endtask

  task automatic drive_load(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] addr,
                            input logic [1:0] size, input logic uns);
    drive_idle();
    ex_pc = pc; ex_rf_we = 1'b1; ex_rf_waddr = wa; ex_result = addr;
    ex_is_load = 1'b1; ex_ld_size = size; ex_ld_unsigned = uns;
  endtask

  // Issue a load, return data on the first WAIT cycle, leave the stage in DONE.
  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         input logic [31:0] rdata);
    drive_load(32'h200, 5'd9, addr, size, uns);
    stall = ST_RUN;
    tick();
    drive_idle();
    stall = ST_HOLD; data_rvalid = 1'b1; data_rdata = rdata;
    tick();
    data_rvalid = 1'b0;
    #1;
  endtask

  task automatic retire;
    stall = ST_RUN; drive_idle();
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = ST_RUN;
    drive_alu(32'h1234, 5'd7, 32'h5555_AAAA);
    tick(); tick();
    n_tests++;
    if ({wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata, wb_hi_we, wb_lo_we, wb_hi, wb_lo} !== '0) begin
      n_fail++; $display("FAIL reset_wb: got pc=%h we=%b wdata=%h, required all zero", wb_pc, wb_rf_we, wb_rf_wdata);
    end
    n_tests++;
    if ({fwd_we, fwd_pending, stallreq_mem, mem_misalign, mem_timeout} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, required 00000",
                         {fwd_we, fwd_pending, stallreq_mem, mem_misalign, mem_timeout});
    end
    rst = 1'b0; drive_idle();
    tick();
  endtask

  task automatic test_lw_latency;
    drive_load(32'h1000, 5'd5, 32'h100, 2'd2, 1'b0);
    stall = ST_RUN;
    tick();
    drive_idle(); stall = ST_HOLD;
    #1;
    for (int k = 1; k <= 3; k++) begin
      n_tests++;
      if (stallreq_mem !== 1'b1 || wb_rf_we !== 1'b0 || fwd_pending !== 1'b1) begin
        n_fail++; $display("FAIL lw_wait_c%0d: got stallreq=%b we=%b pending=%b, required 1 0 1",
                           k, stallreq_mem, wb_rf_we, fwd_pending);
      end
      tick();
    end
    data_rvalid = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if (stallreq_mem !== 1'b0) begin
      n_fail++; $display("FAIL lw_rvalid_release: got stallreq=%b, required 0", stallreq_mem);
    end
    tick();
    data_rvalid = 1'b0;
    #1;
    n_tests++;
    if (wb_rf_wdata !== 32'hDEAD_BEEF || wb_rf_we !== 1'b1 || wb_rf_waddr !== 5'd5 || wb_pc !== 32'h1000) begin
      n_fail++; $display("FAIL lw_result: got wdata=%h we=%b wa=%0d pc=%h, required deadbeef 1 5 00001000",
                         wb_rf_wdata, wb_rf_we, wb_rf_waddr, wb_pc);
    end
    n_tests++;
    if (fwd_pending !== 1'b0 || stallreq_mem !== 1'b0) begin
      n_fail++; $display("FAIL lw_done_ctrl: got pending=%b stallreq=%b, required 0 0", fwd_pending, stallreq_mem);
    end
    retire();
    n_tests++;
    if (wb_rf_we !== 1'b0) begin
      n_fail++; $display("FAIL lw_retire: got we=%b, required 0", wb_rf_we);
    end
  endtask

  task automatic test_load_align;
    logic [31:0] addr_t [8] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101, 32'h100, 32'h104};
    logic [1:0]  size_t [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2};
    logic        uns_t  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] exp_t  [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8011, 32'hFFFF_8011,
                                32'h0000_0033, 32'h0000_0022, 32'h0000_2233, 32'h8011_2233};
    for (int i = 0; i < 8; i++) begin
      do_load(addr_t[i], size_t[i], uns_t[i], 32'h8011_2233);
      n_tests++;
      if (wb_rf_wdata !== exp_t[i] || wb_rf_we !== 1'b1) begin
        n_fail++; $display("FAIL align_%0d: got wdata=%h we=%b, required %h 1", i, wb_rf_wdata, wb_rf_we, exp_t[i]);
      end
      retire();
    end
  endtask

  task automatic test_misalign;
    logic [31:0] addr_t [3] = '{32'h101, 32'h102, 32'h100};
    logic [1:0]  size_t [3] = '{2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 3; i++) begin
      drive_load(32'h300, 5'd7, addr_t[i], size_t[i], 1'b0);
      stall = ST_RUN;
      tick();
      n_tests++;
      if (mem_misalign !== 1'b1 || wb_rf_we !== 1'b0 || fwd_we !== 1'b0 || stallreq_mem !== 1'b0) begin
        n_fail++; $display("FAIL misalign_%0d: got mis=%b we=%b fwd_we=%b stallreq=%b, required 1 0 0 0",
                           i, mem_misalign, wb_rf_we, fwd_we, stallreq_mem);
      end
      drive_idle();
      tick();
      n_tests++;
      if (mem_misalign !== 1'b0 || stallreq_mem !== 1'b0) begin
        n_fail++; $display("FAIL misalign_after_%0d: got mis=%b stallreq=%b, required 0 0",
                           i, mem_misalign, stallreq_mem);
      end
    end
  endtask

  task automatic test_timeout;
    drive_load(32'h400, 5'd6, 32'h200, 2'd2, 1'b0);
    stall = ST_RUN;
    tick();
    drive_idle(); stall = ST_HOLD;
    #1;
    for (int k = 1; k <= TIMEOUT; k++) begin
      n_tests++;
      if (mem_timeout !== (k == TIMEOUT) || stallreq_mem !== 1'b1) begin
        n_fail++; $display("FAIL timeout_c%0d: got timeout=%b stallreq=%b, required %b 1",
                           k, mem_timeout, stallreq_mem, (k == TIMEOUT));
      end
      if (k < TIMEOUT) tick();
    end
    tick();
    n_tests++;
    if (mem_timeout !== 1'b0 || stallreq_mem !== 1'b0 || wb_rf_wdata !== 32'h0 || wb_rf_we !== 1'b1) begin
      n_fail++; $display("FAIL timeout_done: got timeout=%b stallreq=%b wdata=%h we=%b, required 0 0 00000000 1",
                         mem_timeout, stallreq_mem, wb_rf_wdata, wb_rf_we);
    end
    retire();
  endtask

  task automatic test_flush;
    drive_load(32'h500, 5'd8, 32'h100, 2'd2, 1'b0);
    stall = ST_RUN;
    tick();
    drive_idle(); stall = ST_HOLD;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    n_tests++;
    if (stallreq_mem !== 1'b0 || fwd_pending !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle: got stallreq=%b pending=%b, required 0 0", stallreq_mem, fwd_pending);
    end
    data_rvalid = 1'b1; data_rdata = 32'h1234_5678;
    tick();
    data_rvalid = 1'b0;
    #1;
    n_tests++;
    if (wb_rf_wdata !== 32'h0 || wb_rf_we !== 1'b0 || stallreq_mem !== 1'b0) begin
      n_fail++; $display("FAIL flush_stale: got wdata=%h we=%b stallreq=%b, required 00000000 0 0",
                         wb_rf_wdata, wb_rf_we, stallreq_mem);
    end
    stall = ST_RUN;
    drive_alu(32'h504, 5'd2, 32'h55);
    tick();
    n_tests++;
    if (wb_rf_wdata !== 32'h55 || wb_rf_we !== 1'b1) begin
      n_fail++; $display("FAIL flush_next_alu: got wdata=%h we=%b, required 00000055 1", wb_rf_wdata, wb_rf_we);
    end
    retire();
  endtask

  task automatic test_bubble;
    stall = ST_RUN;
    drive_alu(32'h40, 5'd3, 32'hAAAA);
    ex_hi_we = 1'b1; ex_hi = 32'h7; ex_lo_we = 1'b1; ex_lo = 32'h9;
    tick();
    n_tests++;
    if (wb_rf_wdata !== 32'hAAAA || wb_rf_waddr !== 5'd3 || wb_hi !== 32'h7 || wb_lo_we !== 1'b1 || wb_lo !== 32'h9) begin
      n_fail++; $display("FAIL alu_pass: got wdata=%h wa=%0d hi=%h lo_we=%b lo=%h, required 0000aaaa 3 00000007 1 00000009",
                         wb_rf_wdata, wb_rf_waddr, wb_hi, wb_lo_we, wb_lo);
    end
    drive_alu(32'h44, 5'd4, 32'hBBBB);
    stall = ST_HOLD;
    tick();
    n_tests++;
    if (wb_rf_wdata !== 32'hAAAA || wb_pc !== 32'h40) begin
      n_fail++; $display("FAIL hold: got wdata=%h pc=%h, required 0000aaaa 00000040", wb_rf_wdata, wb_pc);
    end
    stall = ST_BUBBLE;
    tick();
    n_tests++;
    if ({wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata, wb_hi_we, wb_lo_we, wb_hi, wb_lo} !== '0) begin
      n_fail++; $display("FAIL bubble: got pc=%h we=%b wdata=%h hi_we=%b, required all zero",
                         wb_pc, wb_rf_we, wb_rf_wdata, wb_hi_we);
    end
    retire();
  endtask

  task automatic test_back_to_back;
    stall = ST_RUN;
    drive_alu(32'h80, 5'd1, 32'h11);
    tick();
    n_tests++;
    if (fwd_we !== 1'b1 || fwd_waddr !== 5'd1 || fwd_wdata !== 32'h11 || stallreq_mem !== 1'b0) begin
      n_fail++; $display("FAIL b2b_alu_fwd: got we=%b wa=%0d wdata=%h stallreq=%b, required 1 1 00000011 0",
                         fwd_we, fwd_waddr, fwd_wdata, stallreq_mem);
    end
    drive_load(32'h84, 5'd2, 32'h102, 2'd1, 1'b1);
    tick();
    n_tests++;
    if (fwd_pending !== 1'b1 || fwd_we !== 1'b0 || stallreq_mem !== 1'b1) begin
      n_fail++; $display("FAIL b2b_load_wait: got pending=%b fwd_we=%b stallreq=%b, required 1 0 1",
                         fwd_pending, fwd_we, stallreq_mem);
    end
    drive_idle(); stall = ST_HOLD; data_rvalid = 1'b1; data_rdata = 32'h8011_2233;
    tick();
    data_rvalid = 1'b0;
    #1;
    n_tests++;
    if (fwd_we !== 1'b1 || fwd_waddr !== 5'd2 || fwd_wdata !== 32'h8011) begin
      n_fail++; $display("FAIL b2b_load_fwd: got we=%b wa=%0d wdata=%h, required 1 2 00008011",
                         fwd_we, fwd_waddr, fwd_wdata);
    end
    stall = ST_RUN;
    drive_alu(32'h88, 5'd3, 32'h33);
    tick();
    n_tests++;
    if (fwd_wdata !== 32'h33 || fwd_pending !== 1'b0 || fwd_waddr !== 5'd3) begin
      n_fail++; $display("FAIL b2b_next_alu: got wdata=%h pending=%b wa=%0d, required 00000033 0 3",
                         fwd_wdata, fwd_pending, fwd_waddr);
    end
    retire();
  endtask

  initial begin
    test_reset();
    test_lw_latency();
    test_load_align();
    test_misalign();
    test_timeout();
    test_flush();
    test_bubble();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
